// File: rtl/roce_stack_dm_cmd_splitter.sv
// RDMA request to AXI datamover command splitter.
// Translates every touched page of one RDMA request and issues one datamover command per page
// chunk, throttled by the number of commands still waiting for a status return.
// Optional build macro ROCE_DM_CMD_STATS_EN adds command, byte and error-status counters.
module roce_stack_dm_cmd_splitter #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned LEN_WIDTH       = 28,
  parameter int unsigned PAGE_SHIFT      = 12,
  parameter int unsigned BTT_WIDTH       = 23,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  clk_i,
  input  logic                  aresetn_i,
  input  logic                  s_rdma_req_valid_i,
  output logic                  s_rdma_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] s_rdma_req_vaddr_i,
  input  logic [LEN_WIDTH-1:0]  s_rdma_req_len_i,
  input  logic                  s_rdma_req_last_i,
  output logic                  req_addr_valid_o,
  input  logic                  req_addr_ready_i,
  output logic [ADDR_WIDTH-1:0] req_addr_vaddr_o,
  input  logic                  resp_addr_valid_i,
  output logic                  resp_addr_ready_o,
  input  logic [ADDR_WIDTH-1:0] resp_addr_paddr_i,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [103:0]          cmd_data_o,
  input  logic                  sts_valid_i,
  output logic                  sts_ready_o,
  input  logic [7:0]            sts_data_i,
  output logic                  busy_o,
  output logic                  err_o
`ifdef ROCE_DM_CMD_STATS_EN
  ,
  output logic [31:0]           stat_cmd_cnt_o,
  output logic [47:0]           stat_byte_cnt_o,
  output logic [15:0]           stat_err_cnt_o
`endif
);

  // Chunk arithmetic must hold both a full page size and any request length.
  localparam int unsigned CW = (LEN_WIDTH > PAGE_SHIFT + 1) ? LEN_WIDTH : PAGE_SHIFT + 1;

  typedef enum logic [1:0] {StIdle, StXlat, StWait, StCmd} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_va_q;
  logic [ADDR_WIDTH-1:0] cur_pa_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic                  last_q;
  logic [3:0]            tag_q;
  logic [3:0]            outstanding_q;
  logic                  err_q;

  logic          req_fire, xlat_fire, resp_fire, cmd_fire, sts_fire, sts_dec, sts_err;
  logic [CW-1:0] page_room, rem_ext, chunk;
  logic          last_chunk, throttled;
  logic          unused_sts_tag;

  assign req_fire  = s_rdma_req_valid_i & s_rdma_req_ready_o;
  assign xlat_fire = req_addr_valid_o & req_addr_ready_i;
  assign resp_fire = resp_addr_valid_i & resp_addr_ready_o;
  assign cmd_fire  = cmd_valid_o & cmd_ready_i;
  assign sts_fire  = sts_valid_i & sts_ready_o;
  // A status with nothing outstanding must not underflow the counter.
  assign sts_dec   = sts_fire & (outstanding_q != 4'd0);
  assign sts_err   = sts_fire & (~sts_data_i[7] | (|sts_data_i[6:4]));

  // Bytes left in the current page; the chunk never crosses a page boundary.
  assign page_room  = (CW'(1) << PAGE_SHIFT) - CW'(cur_va_q[PAGE_SHIFT-1:0]);
  assign rem_ext    = CW'(remaining_q);
  assign last_chunk = (rem_ext <= page_room);
  assign chunk      = last_chunk ? rem_ext : page_room;
  assign throttled  = (outstanding_q >= 4'(MAX_OUTSTANDING));

  assign unused_sts_tag = ^sts_data_i[3:0];

  // State register.
  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_fire && (s_rdma_req_len_i != '0)) state_d = StXlat;
      StXlat: if (xlat_fire) state_d = StWait;
      StWait: if (resp_fire) state_d = StCmd;
      StCmd:  if (cmd_fire) state_d = last_chunk ? StIdle : StXlat;
    endcase
  end

  // Handshake and command outputs decoded from the current state.
  always_comb begin
    // Request port held off while reset is asserted.
    s_rdma_req_ready_o = (state_q == StIdle) & aresetn_i;
    req_addr_valid_o   = (state_q == StXlat);
    resp_addr_ready_o  = (state_q == StWait);
    cmd_valid_o        = (state_q == StCmd) & ~throttled;
    cmd_data_o         = '0;
    if (state_q == StCmd) begin
      cmd_data_o[22:0]   = 23'(chunk);
      cmd_data_o[23]     = 1'b1;
      cmd_data_o[30]     = last_q & last_chunk;
      cmd_data_o[95:32]  = 64'(cur_pa_q);
      cmd_data_o[99:96]  = tag_q;
    end
  end

  assign req_addr_vaddr_o = cur_va_q;
  assign sts_ready_o      = 1'b1;
  assign busy_o           = (state_q != StIdle) | (outstanding_q != 4'd0);
  assign err_o            = err_q;

  // Request context, address walk, tag, outstanding count and sticky error.
  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      cur_va_q      <= '0;
      cur_pa_q      <= '0;
      remaining_q   <= '0;
      last_q        <= 1'b0;
      tag_q         <= 4'd0;
      outstanding_q <= 4'd0;
      err_q         <= 1'b0;
    end else begin
      if (req_fire) begin
        cur_va_q    <= s_rdma_req_vaddr_i;
        remaining_q <= s_rdma_req_len_i;
        last_q      <= s_rdma_req_last_i;
      end
      if (resp_fire) begin
        cur_pa_q <= resp_addr_paddr_i;
      end
      if (cmd_fire) begin
        cur_va_q    <= cur_va_q + ADDR_WIDTH'(chunk);
        cur_pa_q    <= cur_pa_q + ADDR_WIDTH'(chunk);
        remaining_q <= remaining_q - LEN_WIDTH'(chunk);
        tag_q       <= tag_q + 4'd1;
      end
      if (cmd_fire && !sts_dec) begin
        outstanding_q <= outstanding_q + 4'd1;
      end else if (!cmd_fire && sts_dec) begin
        outstanding_q <= outstanding_q - 4'd1;
      end
      if (sts_err) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef ROCE_DM_CMD_STATS_EN
  logic [31:0] stat_cmd_q;
  logic [47:0] stat_byte_q;
  logic [15:0] stat_err_q;

  // Free-running statistics; the error counter saturates instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      stat_cmd_q  <= '0;
      stat_byte_q <= '0;
      stat_err_q  <= '0;
    end else begin
      if (cmd_fire) begin
        stat_cmd_q  <= stat_cmd_q + 32'd1;
        stat_byte_q <= stat_byte_q + 48'(chunk);
      end
      if (sts_err && (stat_err_q != 16'hFFFF)) begin
        stat_err_q <= stat_err_q + 16'd1;
      end
    end
  end

  assign stat_cmd_cnt_o  = stat_cmd_q;
  assign stat_byte_cnt_o = stat_byte_q;
  assign stat_err_cnt_o  = stat_err_q;
`endif

endmodule
